// File: rtl/spi_flash_burst_reader.sv
// SPI mode-0 READ burst engine: streams len+1 bytes from a serial flash over valid/ready.
// Define FLASH_FAST_READ_EN for opcode 0x0B with 8 dummy clocks after the address.
module spi_flash_burst_reader #(
    parameter int CLK_DIV_BITS  = 2,
    parameter int LEN_BITS      = 16,
    parameter int CS_GAP_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [23:0]         addr,
    input  logic [LEN_BITS-1:0] len,
    output logic                busy,
    output logic                done,
    output logic [7:0]          dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                ncs,
    output logic                sck,
    output logic                mosi,
    input  logic                miso
);

`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] OPCODE = 8'h0B;
`else
    localparam logic [7:0] OPCODE = 8'h03;
`endif

    localparam int DIV_W = (CLK_DIV_BITS > 0) ? CLK_DIV_BITS : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'((1 << CLK_DIV_BITS) - 1);
    localparam int GAP_W = $clog2(CS_GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t state, state_next;

    logic [DIV_W-1:0]    div;
    logic                primed;
    logic [4:0]          bit_cnt;
    logic [LEN_BITS-1:0] byte_cnt;
    logic [LEN_BITS-1:0] len_q;
    logic [31:0]         tx_sr;
    logic [6:0]          rx_sr;
    logic [7:0]          pend_byte;
    logic                pending;
    logic                last_byte;
    logic [GAP_W-1:0]    gap_cnt;

    logic       shifting, tick, prime, rise, fall;
    logic       start_acc, byte_done, handshake, gap_ok;
    logic [7:0] new_byte;

    always_comb begin
        shifting   = (state == ST_CMD) || (state == ST_ADDR) ||
                     (state == ST_DUMMY) || (state == ST_DATA);
        tick       = (div == DIV_MAX);
        // First tick after ncs falls only presents bit 31 so mosi has a half-period of setup.
        prime      = shifting && tick && !primed;
        // A completed byte waiting for dout parks sck low before the next byte starts.
        rise       = shifting && tick && primed && !sck && !pending && !last_byte;
        fall       = shifting && tick && primed && sck;
        start_acc  = (state == ST_IDLE) && start;
        byte_done  = rise && (state == ST_DATA) && (bit_cnt[2:0] == 3'd7);
        new_byte   = {rx_sr, miso};
        handshake  = dout_valid && dout_ready;
        gap_ok     = (gap_cnt == GAP_LAST) && !dout_valid && !pending;

        state_next = state;
        case (state)
            ST_IDLE:  if (start_acc) state_next = ST_CMD;
            ST_CMD:   if (rise && bit_cnt == 5'd7) state_next = ST_ADDR;
`ifdef FLASH_FAST_READ_EN
            ST_ADDR:  if (rise && bit_cnt == 5'd31) state_next = ST_DUMMY;
            ST_DUMMY: if (rise && bit_cnt == 5'd7) state_next = ST_DATA;
`else
            ST_ADDR:  if (rise && bit_cnt == 5'd31) state_next = ST_DATA;
`endif
            ST_DATA:  if (fall && last_byte) state_next = ST_GAP;
            ST_GAP:   if (gap_ok) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div        <= '0;
            primed     <= 1'b0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            len_q      <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            pend_byte  <= '0;
            pending    <= 1'b0;
            last_byte  <= 1'b0;
            gap_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ncs        <= 1'b1;
            sck        <= 1'b0;
            mosi       <= 1'b0;
        end else begin
            if (!shifting || tick) div <= '0;
            else                   div <= div + 1'b1;

            if (start_acc) begin
                tx_sr     <= {OPCODE, addr};
                len_q     <= len;
                busy      <= 1'b1;
                ncs       <= 1'b0;
                primed    <= 1'b0;
                bit_cnt   <= '0;
                byte_cnt  <= '0;
                last_byte <= 1'b0;
            end

            if (prime) begin
                primed <= 1'b1;
                mosi   <= tx_sr[31];
            end

            if (rise) begin
                sck <= 1'b1;
                // CMD->ADDR keeps counting so ADDR ends on the 32nd edge.
                if (state_next != state && state != ST_CMD) bit_cnt <= '0;
                else                                         bit_cnt <= bit_cnt + 1'b1;
                if (state == ST_DATA) rx_sr <= new_byte[6:0];
                if (byte_done) begin
                    if (byte_cnt == len_q) last_byte <= 1'b1;
                    else                   byte_cnt  <= byte_cnt + 1'b1;
                end
            end

            if (fall) begin
                sck <= 1'b0;
                if (state == ST_CMD || state == ST_ADDR) begin
                    tx_sr <= {tx_sr[30:0], 1'b0};
                    mosi  <= tx_sr[30];
                end else begin
                    mosi <= 1'b0;
                end
                if (last_byte) begin
                    ncs     <= 1'b1;
                    gap_cnt <= '0;
                end
            end

            if (state == ST_GAP && gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;

            done <= (state == ST_GAP) && gap_ok;
            if (state == ST_GAP && gap_ok) busy <= 1'b0;

            if (byte_done) begin
                if (!dout_valid || handshake) begin
                    dout       <= new_byte;
                    dout_valid <= 1'b1;
                end else begin
                    pend_byte <= new_byte;
                    pending   <= 1'b1;
                end
            end else if (pending && (!dout_valid || handshake)) begin
                dout       <= pend_byte;
                dout_valid <= 1'b1;
                pending    <= 1'b0;
            end else if (handshake) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_burst_reader.sv
// Directed bench for spi_flash_burst_reader with a behavioural SPI-mode-0 flash model.
module tb_spi_flash_burst_reader;
    localparam int CDB = 2;
    localparam int LB  = 2;
    localparam int GAP = 8;
`ifdef FLASH_FAST_READ_EN
    localparam int HDR = 40;
    localparam logic [7:0] OP = 8'h0B;
`else
    localparam int HDR = 32;
    localparam logic [7:0] OP = 8'h03;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [23:0]   addr = '0;
    logic [LB-1:0] len = '0;
    logic          busy, done, dout_valid, ncs, sck, mosi;
    logic [7:0]    dout;
    logic          dout_ready = 1'b1;
    logic          miso = 1'b0;

    spi_flash_burst_reader #(
        .CLK_DIV_BITS(CDB),
        .LEN_BITS(LB),
        .CS_GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .addr(addr), .len(len),
        .busy(busy), .done(done), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .ncs(ncs), .sck(sck), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    // Flash model: captures the 32-bit command word, then shifts mem out on falling sck.
    logic [7:0]  mem [4];
    int          rx_bits = 0;
    int          out_bit = 0;
    logic [31:0] cmd_word = '0;

    always @(posedge sck or negedge sck or posedge ncs) begin
        if (ncs === 1'b1) begin
            rx_bits = 0;
            out_bit = 0;
            miso    = 1'b0;
        end else if (sck === 1'b1) begin
            if (rx_bits < 32) cmd_word = {cmd_word[30:0], mosi};
            rx_bits++;
        end else if (rx_bits >= HDR && out_bit < 32) begin
            miso = mem[out_bit / 8][7 - (out_bit % 8)];
            out_bit++;
        end
    end

    int         done_cnt = 0;
    int         sck_rises = 0;
    int         hi_run = 0;
    int         last_hi = 0;
    logic [7:0] got[$];

    always @(posedge sck) sck_rises++;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (dout_valid && dout_ready) got.push_back(dout);
        if (ncs === 1'b1) hi_run++;
        else begin
            if (hi_run > 0) last_hi = hi_run;
            hi_run = 0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [23:0] a, input logic [LB-1:0] l);
        @(posedge clk); #1;
        start = 1'b1; addr = a; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input string nm);
        int i = 0;
        while (done_cnt == base && i < 8000) begin
            @(posedge clk);
            i++;
        end
        check(nm, done_cnt, base + 1);
    endtask

    typedef struct {
        logic [23:0]   addr;
        logic [LB-1:0] len;
        logic [31:0]   data;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int gbase, rbase, dbase, i;

        vecs[0] = '{24'h012345, 2'd0, 32'hA5000000};
        vecs[1] = '{24'hABCDEF, 2'd3, 32'h11223344};
        vecs[2] = '{24'h000000, 2'd1, 32'h00FF0000};
        vecs[3] = '{24'hFFFFFF, 2'd2, 32'h80017E00};
        vecs[4] = '{24'h000010, 2'd0, 32'h3C000000};

        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout", dout, 8'h00);
        check("rst_valid", dout_valid, 0);
        check("rst_ncs", ncs, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);

        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 4; k++) mem[k] = vecs[v].data[31 - 8 * k -: 8];
            gbase = got.size(); rbase = sck_rises; dbase = done_cnt;
            pulse_start(vecs[v].addr, vecs[v].len);
            check("ncs_latency", ncs, 0);
            check("busy_set", busy, 1);
            wait_done(dbase, "tbl_done");
            @(posedge clk); #1;
            check("tbl_busy_clr", busy, 0);
            check("tbl_cmd", cmd_word, {OP, vecs[v].addr});
            check("tbl_rises", sck_rises - rbase, HDR + 8 * (int'(vecs[v].len) + 1));
            check("tbl_count", got.size() - gbase, int'(vecs[v].len) + 1);
            for (int k = 0; k <= int'(vecs[v].len); k++)
                if (got.size() > gbase + k)
                    check("tbl_byte", got[gbase + k], vecs[v].data[31 - 8 * k -: 8]);
        end

        // Backpressure: consumer idle for 200 clk after the first byte.
        mem[0] = 8'hC3; mem[1] = 8'h5A; mem[2] = 8'h96; mem[3] = 8'h00;
        dout_ready = 1'b0;
        gbase = got.size(); rbase = sck_rises; dbase = done_cnt;
        pulse_start(24'h001122, 2'd2);
        i = 0;
        while (!dout_valid && i < 4000) begin
            @(posedge clk); #1;
            i++;
        end
        check("stall_first_valid", dout_valid, 1);
        check("stall_first_latency", sck_rises - rbase, HDR + 8);
        check("stall_first_byte", dout, 8'hC3);
        repeat (200) @(posedge clk);
        #1;
        check("stall_sck", sck, 0);
        check("stall_ncs", ncs, 0);
        check("stall_dout", dout, 8'hC3);
        check("stall_valid", dout_valid, 1);
        check("stall_rises", sck_rises - rbase, HDR + 16);
        dout_ready = 1'b1;
        wait_done(dbase, "stall_done");
        check("stall_count", got.size() - gbase, 3);
        for (int k = 0; k < 3; k++)
            if (got.size() > gbase + k) check("stall_byte", got[gbase + k], mem[k]);

        // Reset during the 20th address bit aborts with no done.
        dbase = done_cnt; rbase = sck_rises;
        pulse_start(24'h0F0F0F, 2'd1);
        i = 0;
        while (sck_rises - rbase < 28 && i < 4000) begin
            @(negedge clk);
            i++;
        end
        check("abort_reached", sck_rises - rbase, 28);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("abort_ncs", ncs, 1);
        check("abort_sck", sck, 0);
        check("abort_busy", busy, 0);
        check("abort_valid", dout_valid, 0);
        reset_n = 1'b1;
        repeat (100) @(posedge clk);
        check("abort_no_done", done_cnt, dbase);

        // start while busy or in the gap is ignored; next burst accepted in the done cycle.
        mem[0] = 8'h5A;
        dbase = done_cnt; gbase = got.size();
        pulse_start(24'h111111, 2'd0);
        repeat (60) @(posedge clk);
        #1 start = 1'b1; addr = 24'h222222; len = 2'd3;
        @(posedge clk); #1 start = 1'b0;
        check("ign_busy", busy, 1);
        i = 0;
        while (!(ncs === 1'b1 && busy === 1'b1) && i < 4000) begin
            @(negedge clk);
            i++;
        end
        check("ign_gap_seen", ncs && busy, 1);
        start = 1'b1; addr = 24'h333333; len = 2'd0;
        @(negedge clk) start = 1'b0;
        check("ign_cmd", cmd_word, {OP, 24'h111111});
        i = 0;
        while (done !== 1'b1 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("ign_done_seen", done, 1);
        start = 1'b1; addr = 24'h444444; len = 2'd0;
        @(negedge clk) start = 1'b0;
        wait_done(dbase + 1, "ign_done2");
        check("ign_gap_len", last_hi >= GAP, 1);
        check("ign_cmd2", cmd_word, {OP, 24'h444444});
        repeat (300) @(posedge clk);
        check("ign_done_total", done_cnt - dbase, 2);
        check("ign_bytes", got.size() - gbase, 2);
        check("ign_ncs_idle", ncs, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
